// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared frame length, state encoding and sign/saturate helpers for signed PWM
package pwm_pkg;

    typedef enum logic [0:0] {
        SEEK = 1'b0,
        RUN  = 1'b1
    } cap_state_t;

    function automatic int unsigned frame_len(input int unsigned n);
        return 32'd1 << (n - 32'd1);
    endfunction

    // Full-scale magnitude is only representable when negative (-F); positive side clips to F-1.
    function automatic logic [31:0] sign_apply(input logic [31:0] mag, input logic neg,
                                               input logic [31:0] f);
        if (mag == 32'd0)
            return 32'd0;
        if (neg)
            return 32'd0 - mag;
        if (mag >= f)
            return f - 32'd1;
        return mag;
    endfunction

    function automatic logic sign_sat(input logic [31:0] mag, input logic neg,
                                      input logic [31:0] f);
        return !neg && (mag >= f);
    endfunction

endpackage

// File: rtl/pwm_capture_signed_if.sv
// rtl/pwm_capture_signed_if.sv - tick/PWM inputs and recovered-word outputs of the capture block
interface pwm_capture_signed_if #(
    parameter int PWM_IN_SIZE = 10
);
    logic                          CE_in;
    logic                          PWM_in;
    logic                          dir_in;
    logic signed [PWM_IN_SIZE-1:0] PWM_data_output;
    logic                          valid_out;
    logic                          locked_out;
    logic                          sat_out;
    logic                          resync_out;

    modport master (
        output CE_in, PWM_in, dir_in,
        input  PWM_data_output, valid_out, locked_out, sat_out, resync_out
    );

    modport slave (
        input  CE_in, PWM_in, dir_in,
        output PWM_data_output, valid_out, locked_out, sat_out, resync_out
    );
endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with asynchronous active-low reset
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pwm_capture_signed.sv
// rtl/pwm_capture_signed.sv - recovers a signed word per PWM frame from magnitude PWM plus direction
module pwm_capture_signed
    import pwm_pkg::*;
#(
    parameter int PWM_IN_SIZE = 10
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    pwm_capture_signed_if.slave  cap
);
    localparam int          N        = PWM_IN_SIZE;
    localparam int unsigned F        = frame_len(PWM_IN_SIZE);
    localparam logic [N-2:0] LAST_IDX = (N-1)'(F - 1);
    localparam logic [N-2:0] IDX_ONE  = (N-1)'(1);

    logic         pwm_s;
    logic         dir_s;
    logic         pwm_prev;
    logic         rise;
    cap_state_t   state;
    logic [N-2:0] tick_idx;
    logic [N-1:0] high_cnt;
    logic [N-1:0] m_next;

    sync2 u_sync_pwm (.clk(clk_in), .rst_n(reset_n_in), .d(cap.PWM_in), .q(pwm_s));
    sync2 u_sync_dir (.clk(clk_in), .rst_n(reset_n_in), .d(cap.dir_in), .q(dir_s));

    // Edge history advances only on CE ticks so edges are judged at the generator's tick rate.
    assign rise          = cap.CE_in && pwm_s && !pwm_prev;
    assign m_next        = high_cnt + {{(N-1){1'b0}}, pwm_s};
    assign cap.locked_out = (state == RUN);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state               <= SEEK;
            pwm_prev            <= 1'b0;
            tick_idx            <= '0;
            high_cnt            <= '0;
            cap.PWM_data_output <= '0;
            cap.valid_out       <= 1'b0;
            cap.sat_out         <= 1'b0;
            cap.resync_out      <= 1'b0;
        end else begin
            cap.valid_out  <= 1'b0;
            cap.resync_out <= 1'b0;
            if (cap.CE_in) begin
                pwm_prev <= pwm_s;
                if (rise) begin
                    // A rising edge always (re)starts the window; the partial count is dropped.
                    cap.resync_out <= (state == RUN) && (tick_idx != '0);
                    state          <= RUN;
                    tick_idx       <= IDX_ONE;
                    high_cnt       <= N'(1);
                end else begin
                    if (state == RUN && tick_idx == '0)
                        state <= SEEK;
                    if (tick_idx == LAST_IDX) begin
                        cap.PWM_data_output <= N'(sign_apply(32'(m_next), dir_s, 32'(F)));
                        cap.sat_out         <= sign_sat(32'(m_next), dir_s, 32'(F));
                        cap.valid_out       <= 1'b1;
                        tick_idx            <= '0;
                        high_cnt            <= '0;
                    end else begin
                        tick_idx <= tick_idx + IDX_ONE;
                        high_cnt <= m_next;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture_signed.sv
// tb/tb_pwm_capture_signed.sv - self-checking bench for pwm_capture_signed
module tb_pwm_capture_signed;
    localparam int N = 10;
    localparam int F = 512;

    typedef struct {
        int   ce_period;
        int   mag;
        logic neg;
        logic toggle;
        int   exp_val;
        logic exp_sat;
        logic exp_lock;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_capture_signed_if #(.PWM_IN_SIZE(N)) bus ();
    pwm_capture_signed #(.PWM_IN_SIZE(N)) dut (.clk_in(clk), .reset_n_in(rst_n), .cap(bus));

    int   checks = 0;
    int   errors = 0;
    int   resyncs = 0;
    logic hold_bad = 1'b0;

    int   gen_period = 1;
    int   gen_mag = 0;
    int   gen_idx = 0;
    int   gen_cnt = 0;
    logic gen_neg = 1'b0;
    logic gen_toggle = 1'b0;
    logic gen_run = 1'b0;

    // Reference generator: PWM high for the first gen_mag ticks of each F-tick frame.
    always @(negedge clk) begin
        if (!gen_run) begin
            bus.CE_in  = 1'b0;
            bus.PWM_in = 1'b0;
            bus.dir_in = 1'b0;
        end else begin
            bus.CE_in = (gen_cnt == 0);
            if (gen_cnt == 0) begin
                bus.PWM_in = (gen_idx < gen_mag);
                bus.dir_in = gen_toggle ? ~bus.dir_in : gen_neg;
                gen_idx = (gen_idx + 1) % F;
            end
            gen_cnt = (gen_cnt + 1) % gen_period;
        end
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int clks, output logic got);
        logic signed [N-1:0] held;
        held = bus.PWM_data_output;
        got  = 1'b0;
        clks = 0;
        while (!got && clks < budget) begin
            @(posedge clk);
            #1;
            clks++;
            if (bus.resync_out)
                resyncs++;
            if (bus.valid_out)
                got = 1'b1;
            else if (bus.PWM_data_output !== held)
                hold_bad = 1'b1;
        end
    endtask

    task automatic restart(input vec_t v);
        gen_run = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        gen_period = v.ce_period;
        gen_mag    = v.mag;
        gen_neg    = v.neg;
        gen_toggle = v.toggle;
        gen_idx    = 0;
        gen_cnt    = 0;
        hold_bad   = 1'b0;
        #2 rst_n = 1'b1;
        gen_run = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        int   c;
        logic g;

        vecs[0] = '{1,   100, 1'b0, 1'b0,  100, 1'b0, 1'b1};
        vecs[1] = '{1,   512, 1'b1, 1'b0, -512, 1'b0, 1'b0};
        vecs[2] = '{1,   512, 1'b0, 1'b0,  511, 1'b1, 1'b0};
        vecs[3] = '{1,     0, 1'b0, 1'b1,    0, 1'b0, 1'b0};
        vecs[4] = '{4,     1, 1'b1, 1'b0,   -1, 1'b0, 1'b1};
        vecs[5] = '{1,   300, 1'b1, 1'b0, -300, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_data",   bus.PWM_data_output, 0);
        chk("reset_valid",  bus.valid_out, 0);
        chk("reset_locked", bus.locked_out, 0);
        chk("reset_sat",    bus.sat_out, 0);
        chk("reset_resync", bus.resync_out, 0);

        foreach (vecs[i]) begin
            restart(vecs[i]);
            wait_valid(2 * F * vecs[i].ce_period + 200, c, g);
            chk($sformatf("v%0d_first_valid", i), g, 1);
            for (int k = 0; k < 2; k++) begin
                wait_valid(F * vecs[i].ce_period + 50, c, g);
                chk($sformatf("v%0d_p%0d_valid", i, k), g, 1);
                chk($sformatf("v%0d_p%0d_period", i, k), c, F * vecs[i].ce_period);
                chk($sformatf("v%0d_p%0d_data", i, k), bus.PWM_data_output, vecs[i].exp_val);
                chk($sformatf("v%0d_p%0d_sat", i, k), bus.sat_out, vecs[i].exp_sat);
                chk($sformatf("v%0d_p%0d_locked", i, k), bus.locked_out, vecs[i].exp_lock);
            end
            chk($sformatf("v%0d_hold", i), hold_bad, 0);
        end

        // Phase jump while locked: one resync, the disturbed window never publishes.
        restart('{1, 300, 1'b0, 1'b0, 300, 1'b0, 1'b1});
        wait_valid(2 * F + 200, c, g);
        wait_valid(F + 50, c, g);
        chk("pj_locked_before", bus.locked_out, 1);
        chk("pj_data_before", bus.PWM_data_output, 300);
        gen_idx = (gen_idx + 37) % F;
        resyncs = 0;
        wait_valid(2 * F + 100, c, g);
        chk("pj_valid", g, 1);
        chk("pj_resync_count", resyncs, 1);
        chk("pj_gap", c, 2 * F - 37);
        chk("pj_data_after", bus.PWM_data_output, 300);
        chk("pj_locked_after", bus.locked_out, 1);

        // Asynchronous reset in the middle of a locked window.
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mr_data",   bus.PWM_data_output, 0);
        chk("mr_locked", bus.locked_out, 0);
        chk("mr_valid",  bus.valid_out, 0);
        chk("mr_sat",    bus.sat_out, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_valid(3 * F, c, g);
        chk("mr_next_valid", g, 1);
        chk("mr_gap_ge_frame", (c >= F), 1);
        wait_valid(F + 50, c, g);
        chk("mr_data_relock", bus.PWM_data_output, 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
